ibex_alu_seq_ctrl: RTL and testbench
====================================

Name: ibex_alu_seq_ctrl

Overview:
- Request/response sequencer placed in front of the reduced ibex_alu.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operator, operand and instr_first_cycle ports.
- Captures the ALU result and returns it over a valid/ready response channel.
- Implements 32-bit rotates (ROL/ROR) as two ALU shift cycles combined through an internal intermediate register. The reduced ALU has no native rotate.

Parameters:
- RotEn, 1'b1, enables ROL/ROR sequencing; when 0, ROL/ROR are treated as illegal ops.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- flush_i  input  1  synchronous abort of any in-flight or pending operation
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request ready
- req_op_i  input  4  op code:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND
  - 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 ROL, 11 ROR
  - 12-15 illegal
- req_a_i  input  32  operand a
- req_b_i  input  32  operand b; shifts/rotates use [4:0] only
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  response ready
- resp_result_o  output  32  result
- resp_err_o  output  1  illegal op flag
- alu_operator_o  output  ibex_pkg::alu_op_e  ALU operator
- alu_operand_a_o  output  32  ALU operand a
- alu_operand_b_o  output  32  ALU operand b
- alu_instr_first_cycle_o  output  1  ALU first-cycle flag
- alu_multdiv_sel_o  output  1  constant 0
- alu_result_i  input  32  ALU result_o

Behaviour:
- State machine: IDLE, EXEC1, EXEC2, RESP. Reset state is IDLE.
- Reset values:
  - req_ready_o = 1 (IDLE)
  - resp_valid_o = 0, resp_result_o = 0, resp_err_o = 0
  - Request, intermediate and result registers all 0
- req_ready_o = 1 only in IDLE. There is no overlap: a new request is never accepted in the cycle a response is consumed.
- Accept: req_valid_i & req_ready_o at cycle T.
  - Op, a and b are latched.
  - Legal op: go to EXEC1.
  - Illegal op: go to RESP with result 0 and err 1, valid at T+1. The ALU is not used.
- ALU port drive in EXEC1:
  - ALU operands come from the latched a and b.
  - alu_instr_first_cycle_o = 1.
  - Operator per op: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU as named; ROL uses ALU_SLL; ROR uses ALU_SRL.
- Single-cycle ops: alu_result_i is captured at the end of EXEC1 into the result register, err = 0. Next state RESP; resp_valid_o is asserted at T+2.
- Rotate ops: alu_result_i is captured into the intermediate register at the end of EXEC1. Next state EXEC2.
- EXEC2 (rotates only):
  - alu_instr_first_cycle_o = 0, same operands.
  - Operator is the opposite shift: ROL uses ALU_SRL, ROR uses ALU_SLL.
  - With first_cycle = 0 the ALU shifts by (32 - b[4:0]) mod 32.
  - result = intermediate | alu_result_i, captured at end of EXEC2; resp_valid_o asserted at T+3.
- Rotate by 0: both shifts are by 0, so the result equals a. No special case is needed.
- ALU drive in IDLE and RESP: operator ALU_ADD, operands 0, first_cycle 1. alu_multdiv_sel_o is always 0.
- RESP:
  - resp_valid_o = 1; result and err are held stable until resp_ready_i.
  - On handshake, go to IDLE and deassert resp_valid_o the next cycle.
  - resp_ready_i outside RESP is ignored.
- flush_i, synchronous, highest priority:
  - From any state, next state is IDLE.
  - resp_valid_o drops the next cycle; the pending result is discarded.
  - A request presented in the same cycle as flush is not accepted, even in IDLE.
- Async reset mid-operation: state and all registers clear immediately. The in-flight op is lost and no response is produced.
- RotEn = 0: ops 10 and 11 take the illegal path; the EXEC2 state is never entered.

Test Plan:
- ADD: a=5, b=7 accepted at T -> ALU sees ALU_ADD in T+1; resp_valid at T+2, result 0x0000000C, err 0.
- ROL: a=0x80000001, b=4 -> EXEC1 drives ALU_SLL/first=1, EXEC2 drives ALU_SRL/first=0; resp at T+3 = 0x00000018.
- ROR by 0: a=0xDEADBEEF, b=0; then ROR a=0x00000001, b=1 -> results 0xDEADBEEF and 0x80000000.
- Backpressure: hold resp_ready_i=0 for 5 cycles after an SLTU (a=1, b=2) -> result 0x00000001 stays stable and req_ready_o stays 0; handshake, then IDLE next cycle.
- Illegal op 13 -> resp_valid at T+1, err 1, result 0, no ALU op other than ALU_ADD/zeros. With RotEn=0, op 10 gives the same response.
- Abort cases:
  - flush_i in EXEC2 -> IDLE next cycle, no response.
  - rst_ni pulsed low in EXEC1 -> outputs reset immediately.
  - A following ADD (a=1, b=1) returns 2 normally in both cases.

Source files
------------

// File: rtl/ibex_alu_seq_ctrl_if.sv
// Request/response channel bundle between a requester and ibex_alu_seq_ctrl.
// Both channels use a valid/ready handshake; the requester is the master.
interface ibex_alu_seq_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_result, resp_err
   );
endinterface

// File: rtl/ibex_alu_seq_ctrl.sv
// Sequencer in front of the reduced ibex_alu: one op at a time, 1 cycle (illegal), 2 cycles
// (single ALU op) or 3 cycles (rotate) to response; the response is held until resp_ready.
package ibex_pkg;
   typedef enum logic [6:0] {
      ALU_ADD  = 7'd0,
      ALU_SUB  = 7'd1,
      ALU_XOR  = 7'd2,
      ALU_OR   = 7'd3,
      ALU_AND  = 7'd4,
      ALU_SRA  = 7'd8,
      ALU_SRL  = 7'd9,
      ALU_SLL  = 7'd10,
      ALU_SLT  = 7'd11,
      ALU_SLTU = 7'd12
   } alu_op_e;
endpackage

module ibex_alu_seq_ctrl
   import ibex_pkg::*;
#(
   parameter bit RotEn = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   ibex_alu_seq_ctrl_if.slave        bus,
   output alu_op_e                   alu_operator_o,
   output logic [31:0]               alu_operand_a_o,
   output logic [31:0]               alu_operand_b_o,
   output logic                      alu_instr_first_cycle_o,
   output logic                      alu_multdiv_sel_o,
   input  logic [31:0]               alu_result_i
);

   localparam logic [3:0] OpRol = 4'd10;
   localparam logic [3:0] OpRor = 4'd11;

   typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] inter_q, inter_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;

   function automatic logic is_rot(input logic [3:0] op);
      return (op == OpRol) || (op == OpRor);
   endfunction

   function automatic logic op_legal(input logic [3:0] op);
      return (op <= 4'd9) || (RotEn && is_rot(op));
   endfunction

   // Rotates start with the shift that moves bits toward their final position.
   function automatic alu_op_e first_op(input logic [3:0] op);
      case (op)
         4'd0:    return ALU_ADD;
         4'd1:    return ALU_SUB;
         4'd2:    return ALU_XOR;
         4'd3:    return ALU_OR;
         4'd4:    return ALU_AND;
         4'd5:    return ALU_SLL;
         4'd6:    return ALU_SRL;
         4'd7:    return ALU_SRA;
         4'd8:    return ALU_SLT;
         4'd9:    return ALU_SLTU;
         OpRol:   return ALU_SLL;
         OpRor:   return ALU_SRL;
         default: return ALU_ADD;
      endcase
   endfunction

   assign bus.req_ready     = (state_q == IDLE);
   assign bus.resp_valid    = (state_q == RESP);
   assign bus.resp_result   = result_q;
   assign bus.resp_err      = err_q;
   assign alu_multdiv_sel_o = 1'b0;

   always_comb begin
      state_d                 = state_q;
      op_d                    = op_q;
      a_d                     = a_q;
      b_d                     = b_q;
      inter_d                 = inter_q;
      result_d                = result_q;
      err_d                   = err_q;
      alu_operator_o          = ALU_ADD;
      alu_operand_a_o         = '0;
      alu_operand_b_o         = '0;
      alu_instr_first_cycle_o = 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               op_d = bus.req_op;
               a_d  = bus.req_a;
               b_d  = bus.req_b;
               if (op_legal(bus.req_op)) begin
                  state_d = EXEC1;
               end else begin
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = RESP;
               end
            end
         end
         EXEC1: begin
            alu_operator_o  = first_op(op_q);
            alu_operand_a_o = a_q;
            alu_operand_b_o = b_q;
            if (is_rot(op_q)) begin
               inter_d = alu_result_i;
               state_d = EXEC2;
            end else begin
               result_d = alu_result_i;
               err_d    = 1'b0;
               state_d  = RESP;
            end
         end
         EXEC2: begin
            // Second-cycle shift amount is (32 - b) mod 32 inside the ALU.
            alu_operator_o          = (op_q == OpRol) ? ALU_SRL : ALU_SLL;
            alu_operand_a_o         = a_q;
            alu_operand_b_o         = b_q;
            alu_instr_first_cycle_o = 1'b0;
            result_d                = inter_q | alu_result_i;
            err_d                   = 1'b0;
            state_d                 = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) begin
         state_d  = IDLE;
         op_d     = op_q;
         a_d      = a_q;
         b_d      = b_q;
         inter_d  = inter_q;
         result_d = '0;
         err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         inter_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         inter_q  <= inter_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_ibex_alu_seq_ctrl.sv
// Directed bench for ibex_alu_seq_ctrl with a behavioural reduced-ALU model attached.
module tb_ibex_alu_seq_ctrl;
   import ibex_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic flush2 = 1'b0;
   always #5 clk = ~clk;

   ibex_alu_seq_ctrl_if bus ();
   ibex_alu_seq_ctrl_if bus2 ();

   alu_op_e     alu_op,  alu_op2;
   logic [31:0] alu_a,   alu_a2, alu_b, alu_b2, alu_res, alu_res2;
   logic        alu_first, alu_first2, mdsel, mdsel2;

   function automatic logic [31:0] alu_model(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b, input logic first);
      logic [4:0] sh;
      sh = first ? b[4:0] : (5'd0 - b[4:0]);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_XOR:  return a ^ b;
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         ALU_SLL:  return a << sh;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return $unsigned($signed(a) >>> sh);
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         default:  return 32'd0;
      endcase
   endfunction

   assign alu_res  = alu_model(alu_op,  alu_a,  alu_b,  alu_first);
   assign alu_res2 = alu_model(alu_op2, alu_a2, alu_b2, alu_first2);

   ibex_alu_seq_ctrl #(.RotEn(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus),
      .alu_operator_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
      .alu_instr_first_cycle_o(alu_first), .alu_multdiv_sel_o(mdsel), .alu_result_i(alu_res)
   );

   ibex_alu_seq_ctrl #(.RotEn(1'b0)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2), .bus(bus2),
      .alu_operator_o(alu_op2), .alu_operand_a_o(alu_a2), .alu_operand_b_o(alu_b2),
      .alu_instr_first_cycle_o(alu_first2), .alu_multdiv_sel_o(mdsel2), .alu_result_i(alu_res2)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_err;
      int          lat;
      alu_op_e     op1;
      alu_op_e     op2;
      int          hold;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_vec(input vec_t v, input string nm);
      alu_op_e     o1, o2;
      logic        f1, f2;
      int          lat;
      o1 = ALU_ADD; o2 = ALU_ADD; f1 = 1'b0; f2 = 1'b1; lat = 0;
      chk($sformatf("%s.req_ready", nm), 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_op    = v.op;
      bus.req_a     = v.a;
      bus.req_b     = v.b;
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 1) begin o1 = alu_op; f1 = alu_first; end
         if (k == 2) begin o2 = alu_op; f2 = alu_first; end
         if (bus.resp_valid) begin lat = k; break; end
         @(negedge clk);
      end
      chk($sformatf("%s.latency", nm), 32'(lat), 32'(v.lat));
      chk($sformatf("%s.result", nm), bus.resp_result, v.exp_res);
      chk($sformatf("%s.err", nm), 32'(bus.resp_err), 32'(v.exp_err));
      chk($sformatf("%s.op1", nm), 32'(o1), 32'(v.op1));
      if (v.lat == 3) begin
         chk($sformatf("%s.op2", nm), 32'(o2), 32'(v.op2));
         chk($sformatf("%s.first1", nm), 32'(f1), 32'd1);
         chk($sformatf("%s.first2", nm), 32'(f2), 32'd0);
      end
      chk($sformatf("%s.resp_alu_a", nm), alu_a, 32'd0);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk($sformatf("%s.hold_valid", nm), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("%s.hold_result", nm), bus.resp_result, v.exp_res);
         chk($sformatf("%s.hold_req_ready", nm), 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk($sformatf("%s.post_valid", nm), 32'(bus.resp_valid), 32'd0);
      chk($sformatf("%s.post_ready", nm), 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      vec_t v;
      int   seen;
      vecs[0]  = '{4'd0,  32'd5,        32'd7,        32'h0000000C, 1'b0, 2, ALU_ADD,  ALU_ADD, 0};
      vecs[1]  = '{4'd10, 32'h80000001, 32'd4,        32'h00000018, 1'b0, 3, ALU_SLL,  ALU_SRL, 0};
      vecs[2]  = '{4'd11, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0, 3, ALU_SRL,  ALU_SLL, 0};
      vecs[3]  = '{4'd11, 32'h00000001, 32'd1,        32'h80000000, 1'b0, 3, ALU_SRL,  ALU_SLL, 0};
      vecs[4]  = '{4'd9,  32'd1,        32'd2,        32'h00000001, 1'b0, 2, ALU_SLTU, ALU_ADD, 5};
      vecs[5]  = '{4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1, ALU_ADD,  ALU_ADD, 0};
      vecs[6]  = '{4'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 2, ALU_SUB,  ALU_ADD, 0};
      vecs[7]  = '{4'd7,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 2, ALU_SRA,  ALU_ADD, 0};
      vecs[8]  = '{4'd8,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 2, ALU_SLT,  ALU_ADD, 0};
      vecs[9]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 2, ALU_XOR,  ALU_ADD, 0};
      vecs[10] = '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 2, ALU_AND,  ALU_ADD, 0};
      vecs[11] = '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 2, ALU_OR,   ALU_ADD, 0};
      vecs[12] = '{4'd5,  32'd1,        32'd31,       32'h80000000, 1'b0, 2, ALU_SLL,  ALU_ADD, 0};
      vecs[13] = '{4'd6,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 2, ALU_SRL,  ALU_ADD, 0};
      vecs[14] = '{4'd15, 32'd1,        32'd1,        32'h00000000, 1'b1, 1, ALU_ADD,  ALU_ADD, 0};

      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
      bus2.req_valid = 1'b0; bus2.req_op = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.resp_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst.result", bus.resp_result, 32'd0);
      chk("rst.err", 32'(bus.resp_err), 32'd0);
      chk("rst.multdiv", 32'(mdsel), 32'd0);
      chk("rst.alu_op", 32'(alu_op), 32'(ALU_ADD));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Flush while a rotate is in its second cycle.
      bus.req_valid = 1'b1; bus.req_op = 4'd10; bus.req_a = 32'h80000001; bus.req_b = 32'd4;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("flush.in_exec2", 32'(alu_first), 32'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush.req_ready", 32'(bus.req_ready), 32'd1);
      seen = 0;
      repeat (4) begin
         if (bus.resp_valid) seen++;
         @(negedge clk);
      end
      chk("flush.no_resp", 32'(seen), 32'd0);

      // A request that coincides with flush is dropped, even when idle.
      bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_a = 32'd5; bus.req_b = 32'd5;
      flush = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0; flush = 1'b0;
      chk("flush_idle.req_ready", 32'(bus.req_ready), 32'd1);
      chk("flush_idle.alu_a", alu_a, 32'd0);
      v = '{4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 2, ALU_ADD, ALU_ADD, 0};
      run_vec(v, "add_after_flush");

      // Asynchronous reset while in the first execute cycle.
      bus.req_valid = 1'b1; bus.req_op = 4'd1; bus.req_a = 32'd9; bus.req_b = 32'd4;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("arst.in_exec1", 32'(alu_op), 32'(ALU_SUB));
      rst_n = 1'b0;
      #1;
      chk("arst.alu_op", 32'(alu_op), 32'(ALU_ADD));
      chk("arst.alu_a", alu_a, 32'd0);
      chk("arst.req_ready", 32'(bus.req_ready), 32'd1);
      chk("arst.resp_valid", 32'(bus.resp_valid), 32'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      seen = 0;
      repeat (4) begin
         if (bus.resp_valid) seen++;
         @(negedge clk);
      end
      chk("arst.no_resp", 32'(seen), 32'd0);
      run_vec(v, "add_after_arst");

      // Rotate ops take the illegal path when rotates are disabled.
      bus2.req_valid = 1'b1; bus2.req_op = 4'd10; bus2.req_a = 32'h80000001; bus2.req_b = 32'd4;
      @(negedge clk);
      bus2.req_valid = 1'b0;
      chk("norot.resp_valid", 32'(bus2.resp_valid), 32'd1);
      chk("norot.err", 32'(bus2.resp_err), 32'd1);
      chk("norot.result", bus2.resp_result, 32'd0);
      chk("norot.alu_op", 32'(alu_op2), 32'(ALU_ADD));
      bus2.resp_ready = 1'b1;
      @(negedge clk);
      bus2.resp_ready = 1'b0;
      chk("norot.post_valid", 32'(bus2.resp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
